ibex_wb_queue: RTL and testbench

- Multi-entry, in-order writeback stage; generalisation of the single-slot writeback stage.
- Holds up to Depth instructions issued from ID/EX, so several loads/stores can be outstanding at once.
- Retires at most one entry per cycle to the register file.
- Provides per-operand forwarding and hazard detection to ID for both read ports.

---
 rtl/ibex_pkg.sv | 26 ++
 rtl/ibex_wb_fwd_sel.sv | 48 ++++
 rtl/ibex_wb_queue.sv | 188 ++++++++++++++++++
 tb/tb_ibex_wb_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared writeback-queue types: instruction class and the per-entry payload record.
package ibex_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;

    typedef struct packed {
        wb_instr_type_e instr_type;
        logic           we;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic [31:0]    pc;
        logic           compressed;
        logic           count;
        logic           dummy;
    } wb_entry_t;

    // A load owns its destination register even before its data has returned.
    function automatic logic wb_entry_claims_rd(input wb_entry_t e);
        return e.we | (e.instr_type == WB_INSTR_LOAD);
    endfunction

endpackage

// File: rtl/ibex_wb_fwd_sel.sv
// Youngest-match selector for one ID read port: forwards completed results, flags pending loads.
module ibex_wb_fwd_sel
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic [Depth-1:0] valid_i,
    input  wb_entry_t        entries_i [Depth],
    input  logic [PtrW-1:0]  head_i,
    input  logic [4:0]       raddr_i,
    output logic             hit_o,
    output logic             hazard_o,
    output logic [31:0]      data_o
);

    logic [PtrW-1:0] age_idx [Depth];
    logic [Depth:0]  hit_c;
    logic [Depth:0]  haz_c;
    logic [31:0]     data_c [Depth+1];

    assign hit_c[0]  = 1'b0;
    assign haz_c[0]  = 1'b0;
    assign data_c[0] = '0;

    // Walk entries oldest (head) to youngest; a later match overrides an earlier one.
    for (genvar g = 0; g < Depth; g++) begin : g_age
        logic [PtrW:0] sum;
        logic          match;
        logic          is_load;

        assign sum        = {1'b0, head_i} + (PtrW+1)'(g);
        assign age_idx[g] = (sum >= (PtrW+1)'(Depth)) ? PtrW'(sum - (PtrW+1)'(Depth))
                                                      : sum[PtrW-1:0];
        assign is_load    = entries_i[age_idx[g]].instr_type == WB_INSTR_LOAD;
        assign match      = valid_i[age_idx[g]] & wb_entry_claims_rd(entries_i[age_idx[g]]) &
                            (entries_i[age_idx[g]].waddr == raddr_i) & (raddr_i != 5'd0);

        assign hit_c[g+1]  = match ? ~is_load : hit_c[g];
        assign haz_c[g+1]  = match ? is_load  : haz_c[g];
        assign data_c[g+1] = match ? (is_load ? 32'd0 : entries_i[age_idx[g]].wdata) : data_c[g];
    end

    assign hit_o    = hit_c[Depth];
    assign hazard_o = haz_c[Depth];
    assign data_o   = data_c[Depth];

endmodule

// File: rtl/ibex_wb_queue.sv
// In-order multi-entry writeback queue: retires one entry per cycle and serves
// forwarding/hazard information for both ID read ports.
module ibex_wb_queue
    import ibex_pkg::*;
#(
    parameter bit          ResetAll          = 1'b0,
    parameter int unsigned Depth             = 2,
    parameter bit          DummyInstructions = 1'b0,
    localparam int unsigned CntW             = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                en_wb_i,
    input  wb_instr_type_e      instr_type_wb_i,
    input  logic [31:0]         pc_id_i,
    input  logic                instr_is_compressed_id_i,
    input  logic                instr_perf_count_id_i,
    input  logic [4:0]          rf_waddr_id_i,
    input  logic [31:0]         rf_wdata_id_i,
    input  logic                rf_we_id_i,
    input  logic                dummy_instr_id_i,
    input  logic [4:0]          rf_raddr_a_i,
    input  logic [4:0]          rf_raddr_b_i,

    input  logic                lsu_resp_valid_i,
    input  logic                lsu_resp_err_i,
    input  logic [31:0]         rf_wdata_lsu_i,
    input  logic                rf_we_lsu_i,

    output logic                ready_wb_o,
    output logic [4:0]          rf_waddr_wb_o,
    output logic [31:0]         rf_wdata_wb_o,
    output logic                rf_we_wb_o,
    output logic                fwd_hit_a_o,
    output logic                fwd_hit_b_o,
    output logic [31:0]         fwd_data_a_o,
    output logic [31:0]         fwd_data_b_o,
    output logic                hazard_a_o,
    output logic                hazard_b_o,
    output logic                outstanding_load_wb_o,
    output logic                outstanding_store_wb_o,
    output logic [31:0]         pc_wb_o,
    output logic                instr_done_wb_o,
    output logic                perf_instr_ret_wb_o,
    output logic                perf_instr_ret_compressed_wb_o,
    output logic [CntW-1:0]     perf_instr_ret_wb_spec_o,
    output logic [CntW-1:0]     perf_instr_ret_compressed_wb_spec_o,
    output logic                dummy_instr_wb_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Depth-1:0] valid_q, valid_d;
    wb_entry_t        entries_q [Depth];
    wb_entry_t        entries_d [Depth];

    wb_entry_t        head_entry, new_entry;
    logic             head_vld, head_is_other, head_done, enq, rf_we_head;
    logic [Depth-1:0] is_load, is_store, is_cnt, is_cnt_c;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign head_entry    = entries_q[head_q];
    assign head_vld      = valid_q[head_q];
    assign head_is_other = head_entry.instr_type == WB_INSTR_OTHER;
    assign head_done     = head_vld & (head_is_other | lsu_resp_valid_i);
    assign ready_wb_o    = (count_q < CntW'(Depth)) | head_done;
    assign enq           = en_wb_i & ready_wb_o;

    always_comb begin
        new_entry            = '0;
        new_entry.instr_type = instr_type_wb_i;
        new_entry.we         = rf_we_id_i;
        new_entry.waddr      = rf_waddr_id_i;
        new_entry.wdata      = rf_wdata_id_i;
        new_entry.pc         = pc_id_i;
        new_entry.compressed = instr_is_compressed_id_i;
        new_entry.count      = instr_perf_count_id_i;
        new_entry.dummy      = DummyInstructions ? dummy_instr_id_i : 1'b0;
    end

    // When full, head and tail coincide: clearing before setting keeps the slot valid.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        entries_d = entries_q;
        if (head_done) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        if (enq) begin
            valid_d[tail_q]   = 1'b1;
            entries_d[tail_q] = new_entry;
            tail_d            = ptr_inc(tail_q);
        end
        count_d = count_q + CntW'(enq) - CntW'(head_done);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    if (ResetAll) begin : g_payload_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entries_q <= '{default: '0};
            end else begin
                entries_q <= entries_d;
            end
        end
    end else begin : g_payload_nr
        always_ff @(posedge clk_i) begin
            entries_q <= entries_d;
        end
    end

    assign rf_we_head     = head_done & head_is_other & head_entry.we;
    assign rf_we_wb_o     = rf_we_head | rf_we_lsu_i;
    assign rf_wdata_wb_o  = ({32{rf_we_head}} & head_entry.wdata) |
                            ({32{rf_we_lsu_i}} & rf_wdata_lsu_i);
    assign rf_waddr_wb_o  = head_vld ? head_entry.waddr : 5'd0;
    assign pc_wb_o        = head_vld ? head_entry.pc : 32'd0;

    assign instr_done_wb_o                = head_done;
    assign perf_instr_ret_wb_o            = head_done & head_entry.count &
                                            ~(lsu_resp_valid_i & lsu_resp_err_i);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_entry.compressed;
    assign dummy_instr_wb_o               = head_vld & head_entry.dummy;

    for (genvar g = 0; g < Depth; g++) begin : g_flags
        assign is_load[g]  = valid_q[g] & (entries_q[g].instr_type == WB_INSTR_LOAD);
        assign is_store[g] = valid_q[g] & (entries_q[g].instr_type == WB_INSTR_STORE);
        assign is_cnt[g]   = valid_q[g] & entries_q[g].count;
        assign is_cnt_c[g] = is_cnt[g] & entries_q[g].compressed;
    end

    assign outstanding_load_wb_o               = |is_load;
    assign outstanding_store_wb_o              = |is_store;
    assign perf_instr_ret_wb_spec_o            = CntW'($countones(is_cnt));
    assign perf_instr_ret_compressed_wb_spec_o = CntW'($countones(is_cnt_c));

    ibex_wb_fwd_sel #(.Depth(Depth)) u_fwd_a (
        .valid_i   (valid_q),
        .entries_i (entries_q),
        .head_i    (head_q),
        .raddr_i   (rf_raddr_a_i),
        .hit_o     (fwd_hit_a_o),
        .hazard_o  (hazard_a_o),
        .data_o    (fwd_data_a_o)
    );

    ibex_wb_fwd_sel #(.Depth(Depth)) u_fwd_b (
        .valid_i   (valid_q),
        .entries_i (entries_q),
        .head_i    (head_q),
        .raddr_i   (rf_raddr_b_i),
        .hit_o     (fwd_hit_b_o),
        .hazard_o  (hazard_b_o),
        .data_o    (fwd_data_b_o)
    );

`ifndef SYNTHESIS
    // LSU responses always target the head, which must be an outstanding memory op.
    a_we_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({rf_we_head, rf_we_lsu_i}));
    a_resp_head_lsu: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (head_vld && !head_is_other));
    a_resp_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (count_q != '0));
`endif

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed bench for the writeback queue at Depth=3 (exercises non-power-of-2 pointer wrap).
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_ibex_wb_queue;
    import ibex_pkg::*;

    localparam int unsigned Depth = 3;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic clk_i = 1'b0;
    logic rst_ni;
    logic en_wb_i;
    wb_instr_type_e instr_type_wb_i;
    logic [31:0] pc_id_i;
    logic instr_is_compressed_id_i, instr_perf_count_id_i;
    logic [4:0] rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic rf_we_id_i, dummy_instr_id_i;
    logic [4:0] rf_raddr_a_i, rf_raddr_b_i;
    logic lsu_resp_valid_i, lsu_resp_err_i;
    logic [31:0] rf_wdata_lsu_i;
    logic rf_we_lsu_i;

    logic ready_wb_o;
    logic [4:0] rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic rf_we_wb_o;
    logic fwd_hit_a_o, fwd_hit_b_o;
    logic [31:0] fwd_data_a_o, fwd_data_b_o;
    logic hazard_a_o, hazard_b_o;
    logic outstanding_load_wb_o, outstanding_store_wb_o;
    logic [31:0] pc_wb_o;
    logic instr_done_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o;
    logic [CntW-1:0] perf_instr_ret_wb_spec_o, perf_instr_ret_compressed_wb_spec_o;
    logic dummy_instr_wb_o;

    int checks = 0;
    int errors = 0;

    ibex_wb_queue #(.ResetAll(1'b0), .Depth(Depth), .DummyInstructions(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .en_wb_i(en_wb_i), .instr_type_wb_i(instr_type_wb_i), .pc_id_i(pc_id_i),
        .instr_is_compressed_id_i(instr_is_compressed_id_i),
        .instr_perf_count_id_i(instr_perf_count_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
        .dummy_instr_id_i(dummy_instr_id_i),
        .rf_raddr_a_i(rf_raddr_a_i), .rf_raddr_b_i(rf_raddr_b_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
        .rf_wdata_lsu_i(rf_wdata_lsu_i), .rf_we_lsu_i(rf_we_lsu_i),
        .ready_wb_o(ready_wb_o),
        .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o), .rf_we_wb_o(rf_we_wb_o),
        .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o),
        .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o),
        .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
        .outstanding_load_wb_o(outstanding_load_wb_o),
        .outstanding_store_wb_o(outstanding_store_wb_o),
        .pc_wb_o(pc_wb_o), .instr_done_wb_o(instr_done_wb_o),
        .perf_instr_ret_wb_o(perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o(perf_instr_ret_compressed_wb_o),
        .perf_instr_ret_wb_spec_o(perf_instr_ret_wb_spec_o),
        .perf_instr_ret_compressed_wb_spec_o(perf_instr_ret_compressed_wb_spec_o),
        .dummy_instr_wb_o(dummy_instr_wb_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if ((rf_we_wb_o & ~instr_done_wb_o & ~rf_we_lsu_i) !== 1'b0) begin
                errors++;
                $error("FAIL mon_we: RF write without retirement or LSU write");
            end
            if ((perf_instr_ret_wb_o & ~instr_done_wb_o) !== 1'b0) begin
                errors++;
                $error("FAIL mon_ret: retire counter without retirement");
            end
            if (((fwd_hit_a_o & hazard_a_o) | (fwd_hit_b_o & hazard_b_o)) !== 1'b0) begin
                errors++;
                $error("FAIL mon_fwd: forward hit and hazard together");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en_wb_i = 1'b0; instr_type_wb_i = WB_INSTR_OTHER; pc_id_i = 32'd0;
        instr_is_compressed_id_i = 1'b0; instr_perf_count_id_i = 1'b0;
        rf_waddr_id_i = 5'd0; rf_wdata_id_i = 32'd0; rf_we_id_i = 1'b0;
        dummy_instr_id_i = 1'b0; rf_raddr_a_i = 5'd0; rf_raddr_b_i = 5'd0;
        lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
        rf_wdata_lsu_i = 32'd0; rf_we_lsu_i = 1'b0;
    endtask

    // Inputs change on the falling edge; checks follow 1ns later, well clear of the rising edge.
    task automatic next();
        @(negedge clk_i);
        idle();
    endtask

    task automatic enq(input wb_instr_type_e t, input logic [4:0] a, input logic [31:0] d,
                       input logic we, input logic [31:0] pc, input logic comp, input logic dum);
        en_wb_i = 1'b1; instr_type_wb_i = t; rf_waddr_id_i = a; rf_wdata_id_i = d;
        rf_we_id_i = we; pc_id_i = pc; instr_is_compressed_id_i = comp;
        instr_perf_count_id_i = 1'b1; dummy_instr_id_i = dum;
    endtask

    task automatic lsu(input logic we, input logic [31:0] d, input logic err);
        lsu_resp_valid_i = 1'b1; lsu_resp_err_i = err; rf_we_lsu_i = we; rf_wdata_lsu_i = d;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        @(negedge clk_i); #1;
        `CHK("rst_ready", ready_wb_o, 1);
        `CHK("rst_done", instr_done_wb_o, 0);
        `CHK("rst_we", rf_we_wb_o, 0);
        `CHK("rst_spec", perf_instr_ret_wb_spec_o, 0);
        `CHK("rst_oload", outstanding_load_wb_o, 0);
        `CHK("rst_ostore", outstanding_store_wb_o, 0);
        `CHK("rst_pc", pc_wb_o, 0);
        `CHK("rst_dummy", dummy_instr_wb_o, 0);
        rst_ni = 1'b1;

        // Back-to-back OTHER writes retire on consecutive cycles.
        next(); enq(WB_INSTR_OTHER, 5'd5, 32'h11, 1'b1, 32'h100, 1'b0, 1'b0); #1;
        `CHK("b2b_ready0", ready_wb_o, 1);
        `CHK("b2b_nowe0", rf_we_wb_o, 0);
        next(); enq(WB_INSTR_OTHER, 5'd6, 32'h22, 1'b1, 32'h104, 1'b1, 1'b1); #1;
        `CHK("b2b_done1", instr_done_wb_o, 1);
        `CHK("b2b_we1", rf_we_wb_o, 1);
        `CHK("b2b_waddr1", rf_waddr_wb_o, 5);
        `CHK("b2b_wdata1", rf_wdata_wb_o, 32'h11);
        `CHK("b2b_pc1", pc_wb_o, 32'h100);
        `CHK("b2b_ret1", perf_instr_ret_wb_o, 1);
        `CHK("b2b_ready1", ready_wb_o, 1);
        `CHK("b2b_dummy1", dummy_instr_wb_o, 0);
        next(); #1;
        `CHK("b2b_waddr2", rf_waddr_wb_o, 6);
        `CHK("b2b_wdata2", rf_wdata_wb_o, 32'h22);
        `CHK("b2b_retc2", perf_instr_ret_compressed_wb_o, 1);
        `CHK("b2b_specc2", perf_instr_ret_compressed_wb_spec_o, 1);
        `CHK("b2b_dummy2", dummy_instr_wb_o, 1);
        next(); #1;
        `CHK("b2b_empty", instr_done_wb_o, 0);

        // Fill with memory ops, stall, then drain in order via LSU responses.
        next(); enq(WB_INSTR_LOAD, 5'd7, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0); #1;
        next(); enq(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h204, 1'b0, 1'b0);
        rf_raddr_a_i = 5'd7; #1;
        `CHK("lsu_oload", outstanding_load_wb_o, 1);
        `CHK("lsu_nodone", instr_done_wb_o, 0);
        `CHK("lsu_haz_a7", hazard_a_o, 1);
        `CHK("lsu_hit_a7", fwd_hit_a_o, 0);
        next(); enq(WB_INSTR_LOAD, 5'd8, 32'h0, 1'b1, 32'h208, 1'b0, 1'b0); #1;
        `CHK("lsu_ready2", ready_wb_o, 1);
        next(); enq(WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 32'h20C, 1'b0, 1'b0); #1;
        `CHK("full_ready", ready_wb_o, 0);
        `CHK("full_ostore", outstanding_store_wb_o, 1);
        `CHK("full_spec", perf_instr_ret_wb_spec_o, 3);
        next(); enq(WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 32'h20C, 1'b0, 1'b0);
        lsu(1'b1, 32'h77, 1'b0); #1;
        `CHK("ld7_done", instr_done_wb_o, 1);
        `CHK("ld7_we", rf_we_wb_o, 1);
        `CHK("ld7_waddr", rf_waddr_wb_o, 7);
        `CHK("ld7_wdata", rf_wdata_wb_o, 32'h77);
        `CHK("ld7_pc", pc_wb_o, 32'h200);
        `CHK("ld7_ready", ready_wb_o, 1);
        next(); lsu(1'b0, 32'h0, 1'b0); #1;
        `CHK("st_done", instr_done_wb_o, 1);
        `CHK("st_we", rf_we_wb_o, 0);
        `CHK("st_pc", pc_wb_o, 32'h204);
        `CHK("st_spec", perf_instr_ret_wb_spec_o, 3);
        next(); lsu(1'b1, 32'h88, 1'b0); #1;
        `CHK("ld8_waddr", rf_waddr_wb_o, 8);
        `CHK("ld8_wdata", rf_wdata_wb_o, 32'h88);
        `CHK("ld8_pc", pc_wb_o, 32'h208);
        `CHK("ld8_ostore", outstanding_store_wb_o, 0);
        next(); #1;
        `CHK("oth9_done", instr_done_wb_o, 1);
        `CHK("oth9_waddr", rf_waddr_wb_o, 9);
        `CHK("oth9_wdata", rf_wdata_wb_o, 32'h99);
        `CHK("oth9_pc", pc_wb_o, 32'h20C);
        next(); #1;
        `CHK("drain_spec", perf_instr_ret_wb_spec_o, 0);
        `CHK("drain_done", instr_done_wb_o, 0);

        // Forwarding behind a stalled load; youngest writer wins, no same-cycle bypass.
        next(); enq(WB_INSTR_LOAD, 5'd1, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0); #1;
        next(); enq(WB_INSTR_OTHER, 5'd3, 32'hA, 1'b1, 32'h304, 1'b0, 1'b0);
        rf_raddr_a_i = 5'd3; rf_raddr_b_i = 5'd1; #1;
        `CHK("fwd_haz_b1", hazard_b_o, 1);
        `CHK("fwd_hit_b1", fwd_hit_b_o, 0);
        `CHK("fwd_nobypass", fwd_hit_a_o, 0);
        next(); enq(WB_INSTR_OTHER, 5'd3, 32'hB, 1'b1, 32'h308, 1'b0, 1'b0);
        rf_raddr_a_i = 5'd3; #1;
        `CHK("fwd_hit_a_A", fwd_hit_a_o, 1);
        `CHK("fwd_data_a_A", fwd_data_a_o, 32'hA);
        next(); rf_raddr_a_i = 5'd3; rf_raddr_b_i = 5'd0; #1;
        `CHK("fwd_hit_a_B", fwd_hit_a_o, 1);
        `CHK("fwd_data_a_B", fwd_data_a_o, 32'hB);
        `CHK("fwd_nohaz_a", hazard_a_o, 0);
        `CHK("fwd_x0", fwd_hit_b_o, 0);
        `CHK("fwd_full", ready_wb_o, 0);
        next(); enq(WB_INSTR_LOAD, 5'd3, 32'h0, 1'b1, 32'h30C, 1'b0, 1'b0);
        lsu(1'b1, 32'h5, 1'b0); #1;
        `CHK("ld1_waddr", rf_waddr_wb_o, 1);
        `CHK("ld1_wdata", rf_wdata_wb_o, 32'h5);
        `CHK("ld1_ready", ready_wb_o, 1);
        next(); rf_raddr_a_i = 5'd3; #1;
        `CHK("ldhaz_a", hazard_a_o, 1);
        `CHK("ldhaz_hit_a", fwd_hit_a_o, 0);
        `CHK("retA_wdata", rf_wdata_wb_o, 32'hA);
        next(); rf_raddr_a_i = 5'd3; #1;
        `CHK("ldhaz_a2", hazard_a_o, 1);
        `CHK("retB_wdata", rf_wdata_wb_o, 32'hB);
        `CHK("retB_spec", perf_instr_ret_wb_spec_o, 2);

        // Full queue with OTHER head: retire and enqueue together, tail wraps to slot 0.
        next(); enq(WB_INSTR_OTHER, 5'd10, 32'h1010, 1'b1, 32'h400, 1'b0, 1'b0); #1;
        next(); enq(WB_INSTR_OTHER, 5'd11, 32'h1111, 1'b1, 32'h404, 1'b0, 1'b0); #1;
        `CHK("wrap_ready0", ready_wb_o, 1);
        next(); enq(WB_INSTR_OTHER, 5'd12, 32'h1212, 1'b1, 32'h408, 1'b0, 1'b0);
        lsu(1'b1, 32'h33, 1'b0); #1;
        `CHK("ld3_waddr", rf_waddr_wb_o, 3);
        next(); enq(WB_INSTR_OTHER, 5'd13, 32'h1313, 1'b1, 32'h40C, 1'b0, 1'b0); #1;
        `CHK("wrap_ready", ready_wb_o, 1);
        `CHK("wrap_waddr10", rf_waddr_wb_o, 10);
        `CHK("wrap_wdata10", rf_wdata_wb_o, 32'h1010);
        `CHK("wrap_spec_full", perf_instr_ret_wb_spec_o, 3);
        next(); #1;
        `CHK("wrap_spec_kept", perf_instr_ret_wb_spec_o, 3);
        `CHK("wrap_waddr11", rf_waddr_wb_o, 11);
        next(); #1;
        `CHK("wrap_waddr12", rf_waddr_wb_o, 12);
        next(); #1;
        `CHK("wrap_waddr13", rf_waddr_wb_o, 13);
        `CHK("wrap_wdata13", rf_wdata_wb_o, 32'h1313);
        `CHK("wrap_pc13", pc_wb_o, 32'h40C);

        // Load with bus error retires but is not counted.
        next(); enq(WB_INSTR_LOAD, 5'd14, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0); #1;
        next(); lsu(1'b0, 32'h0, 1'b1); #1;
        `CHK("err_spec_before", perf_instr_ret_wb_spec_o, 1);
        `CHK("err_specc_before", perf_instr_ret_compressed_wb_spec_o, 1);
        `CHK("err_done", instr_done_wb_o, 1);
        `CHK("err_ret", perf_instr_ret_wb_o, 0);
        `CHK("err_retc", perf_instr_ret_compressed_wb_o, 0);
        `CHK("err_we", rf_we_wb_o, 0);
        next(); #1;
        `CHK("err_spec_after", perf_instr_ret_wb_spec_o, 0);
        `CHK("err_oload", outstanding_load_wb_o, 0);

        // Reset with three outstanding loads discards everything.
        next(); enq(WB_INSTR_LOAD, 5'd15, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0); #1;
        next(); enq(WB_INSTR_LOAD, 5'd16, 32'h0, 1'b1, 32'h604, 1'b0, 1'b0); #1;
        next(); enq(WB_INSTR_LOAD, 5'd17, 32'h0, 1'b1, 32'h608, 1'b0, 1'b0); #1;
        next(); rf_raddr_b_i = 5'd17; #1;
        `CHK("pre_rst_spec", perf_instr_ret_wb_spec_o, 3);
        `CHK("pre_rst_ready", ready_wb_o, 0);
        `CHK("pre_rst_haz_b", hazard_b_o, 1);
        rst_ni = 1'b0;
        next(); rf_raddr_b_i = 5'd17; #1;
        `CHK("mid_rst_spec", perf_instr_ret_wb_spec_o, 0);
        `CHK("mid_rst_ready", ready_wb_o, 1);
        `CHK("mid_rst_oload", outstanding_load_wb_o, 0);
        `CHK("mid_rst_we", rf_we_wb_o, 0);
        `CHK("mid_rst_haz_b", hazard_b_o, 0);
        rst_ni = 1'b1;
        next(); enq(WB_INSTR_OTHER, 5'd20, 32'h2020, 1'b1, 32'h700, 1'b0, 1'b0); #1;
        `CHK("post_rst_empty", instr_done_wb_o, 0);
        next(); #1;
        `CHK("post_rst_waddr", rf_waddr_wb_o, 20);
        `CHK("post_rst_wdata", rf_wdata_wb_o, 32'h2020);
        `CHK("post_rst_done", instr_done_wb_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
